// File: rtl/accum_pkg.sv
// Shared types for the accumulator readout (drain) stage.
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH,
    DONE
  } drain_state_t;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO with registered head outputs; count includes the head entry.
module drain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_n;
  logic [CW-1:0]    count_n;
  logic [WIDTH-1:0] head_n;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = in_valid && !full;
  assign do_pop  = out_valid && out_ready;

  // A push into an otherwise-empty FIFO bypasses the array straight into the head register.
  always_comb begin
    count_n  = count + CW'(do_push) - CW'(do_pop);
    rd_ptr_n = rd_ptr + AW'(do_pop);
    if (do_push && ((count - CW'(do_pop)) == '0)) begin
      head_n = in_data;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr + AW'(do_push);
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != '0);
      if (count_n != '0) begin
        out_data <= head_n;
      end
    end
  end

endmodule

// File: rtl/accum_drain.sv
// Streams a window of accumulator words out on valid/ready, optionally zeroing
// each entry; reads are issued only against free output-buffer credits.
module accum_drain
  import accum_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_en,
  output logic                  wr_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_wdata,
  output logic                  acc_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(RD_LAT + 1);
  localparam int SW = CW + IW;

  drain_state_t          state;
  drain_state_t          state_n;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   out_cnt;
  logic                  clear_q;
  logic [RD_LAT-1:0]     vld_sr;
  logic [IW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [SW-1:0]         used;
  logic                  credit_ok;
  logic                  issue;
  logic                  pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + IW'(vld_sr[i]);
    end
  end

  // Credits come from registered occupancy only, so a pop frees a slot one cycle later.
  assign used      = SW'(inflight) + SW'(fifo_count);
  assign credit_ok = (used < SW'(FIFO_DEPTH));
  assign issue     = (state == ISSUE) && credit_ok;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (out_cnt == (len_q - 1'b1));

  assign rd_addr  = base_q + issue_cnt[ADDR_WIDTH-1:0];
  assign wr_addr  = rd_addr;
  assign wr_wdata = '0;
  assign acc_mode = 1'b0;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    wr_we   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        busy  = 1'b1;
        rd_en = issue;
        wr_en = issue && clear_q;
        wr_we = issue && clear_q;
        if (issue && ((issue_cnt + 1'b1) == len_q)) begin
          state_n = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (pop && out_last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      clear_q   <= 1'b0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      vld_sr    <= '0;
    end else begin
      state  <= state_n;
      vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
      if ((state == IDLE) && start) begin
        base_q    <= base_addr;
        len_q     <= len;
        clear_q   <= clear_en;
        issue_cnt <= '0;
        out_cnt   <= '0;
      end else begin
        if (issue) begin
          issue_cnt <= issue_cnt + 1'b1;
        end
        if (pop) begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

  drain_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (vld_sr[RD_LAT-1]),
    .in_data  (rd_rdata),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: an accumulator memory stand-in plus a
// window-level model of which addresses/words must appear and when.
module tb_accum_drain;

  localparam int AW         = 9;
  localparam int DW         = 64;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NWORDS     = 512;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          clear_en;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_rdata;
  logic          wr_en;
  logic          wr_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic          acc_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  always #5 clk = ~clk;

  accum_drain #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RD_LAT    (RD_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .clear_en (clear_en),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_rdata (rd_rdata),
    .wr_en    (wr_en),
    .wr_we    (wr_we),
    .wr_addr  (wr_addr),
    .wr_wdata (wr_wdata),
    .acc_mode (acc_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  // Accumulator stand-in: two-stage read pipe, read sees the pre-write value.
  logic [DW-1:0] mem [NWORDS];
  logic [DW-1:0] p1;
  logic [DW-1:0] p2;
  logic          fill_go;

  always @(posedge clk) begin
    if (fill_go) begin
      for (int a = 0; a < NWORDS; a++) mem[a] <= 64'(a + 100);
    end else if (wr_en && wr_we) begin
      mem[wr_addr] <= wr_wdata;
    end
    if (rd_en) p1 <= mem[rd_addr];
    p2 <= p1;
  end

  assign rd_rdata = p2;

  assert property (@(posedge clk) disable iff (!rstn) !(dut.u_fifo.in_valid && dut.u_fifo.full))
    else $error("[TB] FAIL fifo_push_when_full");

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] model_mem [NWORDS];
  logic [AW-1:0] exp_addr [NWORDS];
  logic [DW-1:0] exp_data [NWORDS];
  int            exp_len;
  bit            clr_exp;
  int            rd_idx;
  int            beat_idx;
  int            issued;
  int            accepted;
  int            last_cnt;
  int            done_rel;
  bit            s_busy;
  bit            s_done;
  logic [DW-1:0] got_data [$];
  logic [AW-1:0] got_addr [$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_values();
    check_output("rst_busy",      64'(busy),      64'd0);
    check_output("rst_done",      64'(done),      64'd0);
    check_output("rst_rd_en",     64'(rd_en),     64'd0);
    check_output("rst_wr_en",     64'(wr_en),     64'd0);
    check_output("rst_wr_we",     64'(wr_we),     64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_out_last",  64'(out_last),  64'd0);
    check_output("rst_acc_mode",  64'(acc_mode),  64'd0);
    check_output("rst_rd_addr",   64'(rd_addr),   64'd0);
    check_output("rst_wr_addr",   64'(wr_addr),   64'd0);
    check_output("rst_wr_wdata",  wr_wdata,       64'd0);
    check_output("rst_out_data",  out_data,       64'd0);
  endtask

  // One clock: compare every output against the window model at the falling edge.
  task automatic step(input bit rdy);
    int widx;
    out_ready = rdy;
    @(negedge clk);
    s_busy = busy;
    s_done = done;
    widx   = rd_idx;
    check_output("acc_mode", 64'(acc_mode), 64'd0);
    if (rd_en) begin
      check_output("rd_within_len", 64'(rd_idx < exp_len), 64'd1);
      if (rd_idx < exp_len) check_output("rd_addr", 64'(rd_addr), 64'(exp_addr[rd_idx]));
      got_addr.push_back(rd_addr);
      rd_idx++;
      issued++;
    end
    check_output("wr_en", 64'(wr_en), 64'(rd_en && clr_exp));
    check_output("wr_we", 64'(wr_we), 64'(rd_en && clr_exp));
    if (wr_en && (widx < exp_len)) begin
      check_output("wr_addr",  64'(wr_addr), 64'(exp_addr[widx]));
      check_output("wr_wdata", wr_wdata,     64'd0);
    end
    if (out_valid) begin
      check_output("beat_within_len", 64'(beat_idx < exp_len), 64'd1);
      if (beat_idx < exp_len) begin
        check_output("out_data", out_data,       exp_data[beat_idx]);
        check_output("out_last", 64'(out_last), 64'(beat_idx == exp_len - 1));
      end
      if (out_ready) begin
        got_data.push_back(out_data);
        if (out_last) last_cnt++;
        beat_idx++;
        accepted++;
      end
    end else begin
      check_output("out_last_idle", 64'(out_last), 64'd0);
    end
    check_output("credit_limit", 64'((issued - accepted) <= FIFO_DEPTH), 64'd1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic build_model(input logic [AW-1:0] base, input int n, input bit clr);
    int a;
    exp_len  = n;
    clr_exp  = clr;
    rd_idx   = 0;
    beat_idx = 0;
    issued   = 0;
    accepted = 0;
    last_cnt = 0;
    done_rel = -1;
    got_data.delete();
    got_addr.delete();
    for (int i = 0; i < n; i++) begin
      a           = (int'(base) + i) % NWORDS;
      exp_addr[i] = AW'(a);
      exp_data[i] = model_mem[a];
      if (clr) model_mem[a] = '0;
    end
  endtask

  task automatic apply_stimulus(input logic [AW-1:0] base, input int n, input bit clr,
                                input bit bp, input bit poke);
    build_model(base, n, clr);
    start     = 1'b1;
    base_addr = base;
    len       = (AW + 1)'(n);
    clear_en  = clr;
    step(1'b1);
    check_output("busy_at_start", 64'(s_busy), 64'd0);
    start     = 1'b0;
    base_addr = ~base;
    len       = '1;
    clear_en  = ~clr;
    for (int k = 1; k <= 3000; k++) begin
      if (poke && (k == 3)) begin
        start     = 1'b1;
        base_addr = 9'h100;
        len       = 10'd1;
        clear_en  = 1'b1;
      end else begin
        start = 1'b0;
      end
      step(bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1);
      check_output("busy_during_run", 64'(s_busy), 64'd1);
      if (s_done) begin
        done_rel = k;
        break;
      end
    end
    if (done_rel < 0) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    start = 1'b0;
    step(1'b1);
    check_output("done_one_cycle",   64'(s_done),   64'd0);
    check_output("busy_after_done",  64'(s_busy),   64'd0);
    check_output("reads_issued",     64'(rd_idx),   64'(n));
    check_output("beats_accepted",   64'(beat_idx), 64'(n));
    check_output("last_count",       64'(last_cnt), 64'(n > 0));
    if (!bp) check_output("done_latency", 64'(done_rel), 64'((n == 0) ? 1 : 3 + RD_LAT + n - 1));
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    clear_en  = 1'b0;
    out_ready = 1'b0;
    fill_go   = 1'b1;
    build_model(9'h000, 0, 1'b0);
    for (int a = 0; a < NWORDS; a++) model_mem[a] = 64'(a + 100);
    @(posedge clk);
    #1;
    fill_go = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1'b1);
    step(1'b1);

    // basic drain
    apply_stimulus(9'h010, 4, 1'b0, 1'b0, 1'b0);
    check_output("basic_count", 64'(got_data.size()), 64'd4);
    if (got_data.size() == 4) begin
      check_output("basic_beat0", got_data[0], 64'h74);
      check_output("basic_beat1", got_data[1], 64'h75);
      check_output("basic_beat2", got_data[2], 64'h76);
      check_output("basic_beat3", got_data[3], 64'h77);
    end
    check_output("basic_done_t8", 64'(done_rel), 64'd8);

    // wrap-around
    apply_stimulus(9'h1FE, 4, 1'b0, 1'b0, 1'b0);
    if ((got_addr.size() == 4) && (got_data.size() == 4)) begin
      check_output("wrap_addr0", 64'(got_addr[0]), 64'h1FE);
      check_output("wrap_addr1", 64'(got_addr[1]), 64'h1FF);
      check_output("wrap_addr2", 64'(got_addr[2]), 64'h000);
      check_output("wrap_addr3", 64'(got_addr[3]), 64'h001);
      check_output("wrap_data0", got_data[0], 64'h262);
      check_output("wrap_data2", got_data[2], 64'h064);
    end else begin
      check_output("wrap_count", 64'(got_data.size()), 64'd4);
    end

    // backpressure 1,0,0,1
    apply_stimulus(9'h080, 16, 1'b0, 1'b1, 1'b0);

    // clear then re-drain
    apply_stimulus(9'h020, 8, 1'b1, 1'b0, 1'b0);
    if (got_data.size() == 8) begin
      check_output("clear_old0", got_data[0], 64'h84);
      check_output("clear_old7", got_data[7], 64'h8B);
    end
    apply_stimulus(9'h020, 8, 1'b0, 1'b0, 1'b0);
    check_output("cleared_count", 64'(got_data.size()), 64'd8);
    foreach (got_data[i]) check_output("cleared_zero", got_data[i], 64'd0);

    // len = 0
    apply_stimulus(9'h055, 0, 1'b0, 1'b0, 1'b0);
    check_output("len0_done_t1", 64'(done_rel), 64'd1);

    // start while busy
    apply_stimulus(9'h030, 6, 1'b0, 1'b0, 1'b1);

    // full sweep
    apply_stimulus(9'h005, 512, 1'b0, 1'b0, 1'b0);
    check_output("sweep_last_once", 64'(last_cnt), 64'd1);
    check_output("sweep_done_t516", 64'(done_rel), 64'd516);

    // reset mid-drain after three accepted beats
    build_model(9'h040, 10, 1'b0);
    start     = 1'b1;
    base_addr = 9'h040;
    len       = 10'd10;
    clear_en  = 1'b0;
    step(1'b1);
    start = 1'b0;
    for (int k = 0; (k < 100) && (accepted < 3); k++) step(1'b1);
    check_output("pre_reset_beats", 64'(accepted), 64'd3);
    rstn = 1'b0;
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc++;
    build_model(9'h040, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      check_output("post_reset_no_done", 64'(s_done), 64'd0);
      check_output("post_reset_idle",    64'(s_busy), 64'd0);
    end
    apply_stimulus(9'h040, 10, 1'b0, 1'b0, 1'b0);
    if (got_data.size() == 10) check_output("rerun_beat0", got_data[0], 64'hA4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
